sample_trigger_capture: RTL and testbench

//   Parametrised scope acquisition block: edge trigger on a programmable level/slope, pre-trigger ring buffer,

---
 rtl/sample_trigger_capture.sv | 163 ++++++++++++++++
 tb/tb_sample_trigger_capture.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_trigger_capture.sv
// Scope acquisition: level/slope edge trigger, pre-trigger history, auto/normal/single modes and
// ping-pong frame banks so the renderer always reads a stable, trigger-aligned frame.
module sample_trigger_capture #(
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned DEPTH        = 800,
  parameter int unsigned PTR_W        = 10,
  parameter int unsigned X_W          = 11,
  parameter int unsigned PRE_TRIG     = 400,
  parameter int unsigned AUTO_TIMEOUT = 2000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic [X_W-1:0]    screenX,
  output logic [DATA_W-1:0] screenData,
  output logic              frame_valid,
  output logic              triggered,
  output logic              auto_forced
);

  localparam int unsigned POST_N  = DEPTH - PRE_TRIG - 1;
  localparam int unsigned CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PW1     = PTR_W + 1;

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_E   = PW1'(DEPTH);
  localparam logic [PTR_W:0]   PRE_E     = PW1'(PRE_TRIG);
  localparam logic [X_W-1:0]   DEPTH_X   = X_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(AUTO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'((POST_N == 0) ? 0 : POST_N - 1);

  typedef enum logic [1:0] {StFill, StArmed, StPost, StDone} state_e;

  state_e            state;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  trig_ptr;
  logic [PTR_W-1:0]  dstart;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              wbank;
  logic              dbank;

  logic [PTR_W-1:0]  wptr_inc;
  logic [PTR_W-1:0]  pub_ptr;
  logic [PTR_W-1:0]  start_calc;
  logic [PTR_W-1:0]  raddr;
  logic [PTR_W:0]    rsum;
  logic [DATA_W-1:0] rdata;
  logic              edge_hit;
  logic              force_hit;
  logic              trig_hit;
  logic              publish;
  logic              we;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  always_comb begin
    wptr_inc  = (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
    edge_hit  = prev_valid && (trig_slope ? (prev > trig_level && data <= trig_level)
                                          : (prev < trig_level && data >= trig_level));
    force_hit = (mode == 2'd0) && (cnt == TO_LAST);
    trig_hit  = sample_en && (state == StArmed) && (edge_hit || force_hit);
    publish   = (sample_en && state == StPost && cnt == POST_LAST) || (POST_N == 0 && trig_hit);
    we        = sample_en && (state != StDone);

    // With no post-trigger samples the frame closes on the trigger sample itself.
    pub_ptr    = (state == StArmed) ? wptr : trig_ptr;
    start_calc = ({1'b0, pub_ptr} < PRE_E) ? PTR_W'({1'b0, pub_ptr} + DEPTH_E - PRE_E)
                                           : PTR_W'({1'b0, pub_ptr} - PRE_E);

    rsum  = {1'b0, dstart} + {1'b0, screenX[PTR_W-1:0]};
    raddr = (rsum >= DEPTH_E) ? PTR_W'(rsum - DEPTH_E) : PTR_W'(rsum);
    rdata = dbank ? mem1[raddr] : mem0[raddr];
  end

  // Frame storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      if (wbank) mem1[wptr] <= data;
      else       mem0[wptr] <= data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= StFill;
      wptr        <= '0;
      trig_ptr    <= '0;
      dstart      <= '0;
      cnt         <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      wbank       <= 1'b0;
      dbank       <= 1'b1;
      screenData  <= '0;
      frame_valid <= 1'b0;
      triggered   <= 1'b0;
      auto_forced <= 1'b0;
    end else begin
      triggered   <= 1'b0;
      auto_forced <= 1'b0;
      screenData  <= (frame_valid && screenX < DEPTH_X) ? rdata : '0;

      if (state == StDone) begin
        if (arm) begin
          state      <= StFill;
          cnt        <= '0;
          prev_valid <= 1'b0;
        end
      end else if (sample_en) begin
        wptr       <= wptr_inc;
        prev       <= data;
        prev_valid <= 1'b1;
        unique case (state)
          StFill: begin
            if (cnt == FILL_LAST) begin
              state <= StArmed;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StArmed: begin
            if (trig_hit) begin
              trig_ptr    <= wptr;
              triggered   <= 1'b1;
              auto_forced <= !edge_hit;
              state       <= StPost;
              cnt         <= '0;
            end else if (cnt != TO_LAST) begin
              // Saturate so a later switch to auto mode forces on the next sample.
              cnt <= cnt + 1'b1;
            end
          end
          StPost: begin
            if (!publish) cnt <= cnt + 1'b1;
          end
          default: ;
        endcase

        if (publish) begin
          dbank       <= wbank;
          wbank       <= ~wbank;
          dstart      <= start_calc;
          frame_valid <= 1'b1;
          cnt         <= '0;
          prev_valid  <= 1'b0;
          state       <= (mode == 2'd2) ? StDone : StFill;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_trigger_capture.sv
// Bench for sample_trigger_capture: a frame-level reference model (sample history queue, published
// frame array) checked every cycle, plus literal column values for directed scenarios.
module tb_sample_trigger_capture;

  localparam int DEPTH        = 800;
  localparam int PRE_TRIG     = 400;
  localparam int AUTO_TIMEOUT = 2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [13:0] data = '0;
  logic [13:0] trig_level = '0;
  logic        trig_slope = 1'b0;
  logic [1:0]  mode = 2'd1;
  logic        arm = 1'b0;
  logic [10:0] screenX = '0;
  logic [13:0] screenData;
  logic        frame_valid;
  logic        triggered;
  logic        auto_forced;

  sample_trigger_capture dut (
    .clock       (clock),
    .reset       (reset),
    .sample_en   (sample_en),
    .data        (data),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .mode        (mode),
    .arm         (arm),
    .screenX     (screenX),
    .screenData  (screenData),
    .frame_valid (frame_valid),
    .triggered   (triggered),
    .auto_forced (auto_forced)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model state: samples of the frame being captured and the published frame.
  logic [13:0] cap[$];
  logic [13:0] disp [DEPTH];
  int          n_cap = 0;
  bit          m_trig = 0;
  bit          m_done = 0;
  bit          m_valid = 0;
  logic [13:0] exp_sd = '0;
  bit          exp_fv = 0;
  bit          exp_tr = 0;
  bit          exp_af = 0;

  int  acc_count = 0;
  int  trig_count = 0;
  int  forced_count = 0;
  int  dut_trig_at = -1;
  bit  checking = 0;

  // Stimulus generator state.
  int  kind = 0;
  int  en_div = 1;
  int  sidx = 0;
  int  phase = 0;
  bit  rand_x = 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step();
    logic [13:0] pr;
    bit e;
    if (!reset) begin
      cap.delete();
      n_cap = 0; m_trig = 0; m_done = 0; m_valid = 0;
      exp_sd = '0; exp_fv = 0; exp_tr = 0; exp_af = 0;
      return;
    end
    exp_sd = (m_valid && int'(screenX) < DEPTH) ? disp[screenX] : '0;
    exp_tr = 0;
    exp_af = 0;
    if (sample_en) acc_count++;
    if (m_done) begin
      if (arm) begin
        m_done = 0;
        cap.delete();
        n_cap = 0;
      end
    end else if (sample_en) begin
      cap.push_back(data);
      n_cap++;
      if (!m_trig && n_cap > PRE_TRIG) begin
        pr = cap[cap.size() - 2];
        e = trig_slope ? (pr > trig_level && data <= trig_level)
                       : (pr < trig_level && data >= trig_level);
        if (e || (mode == 2'd0 && n_cap - PRE_TRIG >= AUTO_TIMEOUT)) begin
          m_trig = 1; exp_tr = 1; exp_af = !e;
        end else begin
          void'(cap.pop_front());
        end
      end
      if (m_trig && cap.size() == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) disp[i] = cap[i];
        m_valid = 1;
        cap.delete();
        n_cap = 0;
        m_trig = 0;
        m_done = (mode == 2'd2);
      end
    end
    exp_fv = m_valid;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (checking) begin
      chk("screenData", int'(screenData), reset ? int'(exp_sd) : 0);
      chk("frame_valid", int'(frame_valid), reset ? int'(exp_fv) : 0);
      chk("triggered", int'(triggered), reset ? int'(exp_tr) : 0);
      chk("auto_forced", int'(auto_forced), reset ? int'(exp_af) : 0);
    end
    if (triggered) begin
      trig_count++;
      dut_trig_at = acc_count;
    end
    if (auto_forced) forced_count++;
  end

  function automatic logic [13:0] gen(input int k);
    case (kind)
      0:       return 14'(k % 1024);
      1:       return 14'(1023 - (k % 1024));
      2:       return 14'(0);
      default: return 14'($urandom_range(0, 16383));
    endcase
  endfunction

  task automatic cyc();
    bit en;
    @(negedge clock);
    en = (en_div == 0) ? ($urandom_range(0, 2) != 0) : ((phase % en_div) == 0);
    phase++;
    sample_en = en;
    data = gen(sidx);
    if (en) sidx++;
    if (rand_x) screenX = 11'($urandom_range(0, 1023));
  endtask

  task automatic peek(input string name, input int x, input int expv);
    @(negedge clock);
    sample_en = 1'b0;
    screenX = 11'(x);
    @(negedge clock);
    chk(name, int'(screenData), expv);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    sample_en = 1'b0;
    arm = 1'b0;
    repeat (3) @(negedge clock);
    acc_count = 0; trig_count = 0; forced_count = 0; dut_trig_at = -1;
    sidx = 0; phase = 0;
    reset = 1'b1;
  endtask

  task automatic run_until_valid(input string name, input int budget);
    int i;
    i = 0;
    while (!frame_valid && i < budget) begin
      cyc();
      i++;
    end
    chk(name, int'(frame_valid), 1);
  endtask

  task automatic test_ramp_up(input string tag);
    kind = 0; en_div = 1; trig_level = 14'd500; trig_slope = 1'b0; mode = 2'd1;
    run_until_valid({tag, "_valid"}, 3000);
    chk({tag, "_trig_sample"}, dut_trig_at, 501);
    chk({tag, "_forced"}, forced_count, 0);
    peek({tag, "_x0"}, 0, 100);
    peek({tag, "_x400"}, 400, 500);
    peek({tag, "_x799"}, 799, 899);
  endtask

  initial begin
    int i;
    do_reset();
    checking = 1;
    chk("reset_frame_valid", int'(frame_valid), 0);
    chk("reset_screenData", int'(screenData), 0);

    // Rising ramp, normal mode.
    test_ramp_up("t1");

    // Falling ramp.
    do_reset();
    kind = 1; trig_level = 14'd300; trig_slope = 1'b1; mode = 2'd1;
    run_until_valid("t2_valid", 3000);
    chk("t2_trig_sample", dut_trig_at, 724);
    peek("t2_x400", 400, 300);
    peek("t2_x0", 0, 700);

    // Constant input: auto forces, normal waits forever.
    do_reset();
    kind = 2; trig_level = 14'd100; trig_slope = 1'b0; mode = 2'd0;
    run_until_valid("t3_valid", 3000);
    chk("t3_trig_sample", dut_trig_at, 2400);
    chk("t3_forced", forced_count, 1);
    do_reset();
    kind = 2; mode = 2'd1;
    repeat (3000) cyc();
    chk("t3n_trig_count", trig_count, 0);
    chk("t3n_frame_valid", int'(frame_valid), 0);
    peek("t3n_x400", 400, 0);

    // Single mode, then re-arm.
    do_reset();
    kind = 0; trig_level = 14'd500; trig_slope = 1'b0; mode = 2'd2;
    run_until_valid("t4_valid", 3000);
    peek("t4_x400", 400, 500);
    kind = 3;
    repeat (300) cyc();
    peek("t4_hold_x400", 400, 500);
    chk("t4_hold_trig_count", trig_count, 1);
    kind = 0;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    repeat (2000) cyc();
    chk("t4_rearm_trig_count", trig_count, 2);
    peek("t4_rearm_x400", 400, 500);
    peek("t4_rearm_x0", 0, 100);

    // Sparse sample_en and out-of-range columns.
    do_reset();
    kind = 0; en_div = 4; trig_level = 14'd500; trig_slope = 1'b0; mode = 2'd1;
    run_until_valid("t5_valid", 12000);
    chk("t5_trig_sample", dut_trig_at, 501);
    peek("t5_x0", 0, 100);
    peek("t5_x400", 400, 500);
    peek("t5_x799", 799, 899);
    peek("t5_x800", 800, 0);
    peek("t5_x2047", 2047, 0);
    en_div = 1;

    // Asynchronous reset in the middle of a post-trigger capture.
    do_reset();
    test_ramp_up("t6a");
    i = 0;
    while (trig_count < 2 && i < 3000) begin
      cyc();
      i++;
    end
    chk("t6_second_trig", trig_count, 2);
    repeat (50) cyc();
    rand_x = 0;
    screenX = 11'd400;
    cyc();
    cyc();
    chk("t6_pre_reset_sd", int'(screenData), 500);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_sd", int'(screenData), 0);
    chk("t6_async_fv", int'(frame_valid), 0);
    chk("t6_async_trig", int'(triggered), 0);
    rand_x = 1;
    do_reset();
    test_ramp_up("t6b");

    // Randomised traffic against the model.
    do_reset();
    kind = 3; en_div = 0;
    for (int c = 0; c < 30; c++) begin
      mode = 2'($urandom_range(0, 3));
      trig_level = 14'($urandom_range(0, 16383));
      trig_slope = 1'($urandom_range(0, 1));
      for (int k = 0; k < 200; k++) begin
        arm = ($urandom_range(0, 49) == 0);
        cyc();
      end
    end
    arm = 1'b0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
